// File: rtl/rr_arbiter_ctrl_if.sv
// rtl/rr_arbiter_ctrl_if.sv - requester/grant bundle between front-ends and the round-robin arbiter
interface rr_arbiter_ctrl_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] Req_DI;
  logic [NUM_REQ-1:0] Done_DI;
  logic [NUM_REQ-1:0] Gnt_DO;
  logic [IDX_W-1:0]   GntIdx_DO;
  logic               Busy_SO;
  logic               Preempt_SO;

  // Requester side: raises requests and releases, observes grants
  modport master (
    output Req_DI,
    output Done_DI,
    input  Gnt_DO,
    input  GntIdx_DO,
    input  Busy_SO,
    input  Preempt_SO
  );

  // Arbiter side
  modport slave (
    input  Req_DI,
    input  Done_DI,
    output Gnt_DO,
    output GntIdx_DO,
    output Busy_SO,
    output Preempt_SO
  );
endinterface

// File: rtl/rr_arbiter_ctrl.sv
// rtl/rr_arbiter_ctrl.sv - round-robin arbiter with bounded hold time and one-cycle owner turnaround
module rr_arbiter_ctrl #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic              Clk_CI,
  input  logic              Rst_RI,
  rr_arbiter_ctrl_if.slave  arb
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               preempt_q, preempt_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic               own_done;
  logic               own_req;
  logic               hold_out;

  // Search requests starting at the pointer and wrapping; the first set bit wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!win_found && arb.Req_DI[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign own_done = arb.Done_DI[idx_q];
  assign own_req  = arb.Req_DI[idx_q];
  assign hold_out = (cnt_q == CNT_W'(MAX_HOLD - 1));

  // Next-state and next-output decode; registered outputs change only through here
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    preempt_d = 1'b0;
    unique case (state_q)
      IDLE, RELEASE: begin
        if (win_found) begin
          state_d        = GRANT;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          idx_d          = win_idx;
          cnt_d          = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      GRANT: begin
        if (own_done || !own_req || hold_out) begin
          state_d   = RELEASE;
          gnt_d     = '0;
          cnt_d     = '0;
          ptr_d     = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
          // Only a pure timeout counts as preemption; a voluntary release wins the tie
          preempt_d = hold_out && !own_done && own_req;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset wins over everything and never pulses preempt
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      idx_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      preempt_q <= preempt_d;
    end
  end

  assign arb.Gnt_DO     = gnt_q;
  assign arb.GntIdx_DO  = idx_q;
  assign arb.Busy_SO    = |gnt_q;
  assign arb.Preempt_SO = preempt_q;
endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// tb/tb_rr_arbiter_ctrl.sv - directed self-checking bench for rr_arbiter_ctrl
module tb_rr_arbiter_ctrl;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  rr_arbiter_ctrl_if #(.NUM_REQ(4)) arb ();

  rr_arbiter_ctrl #(
    .NUM_REQ (4),
    .MAX_HOLD(16)
  ) dut (
    .Clk_CI(clk),
    .Rst_RI(rst),
    .arb   (arb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] owners [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    arb.Req_DI  = '0;
    arb.Done_DI = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("rst_gnt", 32'(arb.Gnt_DO), 32'h0);
    check("rst_idx", 32'(arb.GntIdx_DO), 32'h0);
    check("rst_busy", 32'(arb.Busy_SO), 32'h0);
    check("rst_preempt", 32'(arb.Preempt_SO), 32'h0);

    // Single request, explicit done, then back to idle
    tick();
    arb.Req_DI = 4'b0010;
    tick();
    check("t1_gnt", 32'(arb.Gnt_DO), 32'h2);
    check("t1_idx", 32'(arb.GntIdx_DO), 32'h1);
    check("t1_busy", 32'(arb.Busy_SO), 32'h1);
    tick();
    tick();
    check("t1_hold", 32'(arb.Gnt_DO), 32'h2);
    arb.Done_DI = 4'b0010;
    tick();
    check("t1_rel_gnt", 32'(arb.Gnt_DO), 32'h0);
    check("t1_rel_pre", 32'(arb.Preempt_SO), 32'h0);
    check("t1_rel_idx", 32'(arb.GntIdx_DO), 32'h1);
    arb.Done_DI = '0;
    arb.Req_DI  = '0;
    tick();
    check("t1_idle_gnt", 32'(arb.Gnt_DO), 32'h0);
    check("t1_idle_busy", 32'(arb.Busy_SO), 32'h0);

    // Two requesters alternate, each releasing in its third grant cycle
    do_reset();
    owners[0] = 4'b0001;
    owners[1] = 4'b0100;
    owners[2] = 4'b0001;
    owners[3] = 4'b0100;
    arb.Req_DI = 4'b0101;
    tick();
    for (int k = 0; k < 4; k++) begin
      for (int c = 1; c <= 3; c++) begin
        check($sformatf("t2_gnt_k%0d_c%0d", k, c), 32'(arb.Gnt_DO), 32'(owners[k]));
        check($sformatf("t2_pre_k%0d_c%0d", k, c), 32'(arb.Preempt_SO), 32'h0);
        if (c == 3) arb.Done_DI = owners[k];
        tick();
      end
      check($sformatf("t2_gap_k%0d", k), 32'(arb.Gnt_DO), 32'h0);
      check($sformatf("t2_gap_pre_k%0d", k), 32'(arb.Preempt_SO), 32'h0);
      arb.Done_DI = '0;
      tick();
    end
    check("t2_fifth", 32'(arb.Gnt_DO), 32'h1);
    arb.Req_DI = '0;
    tick();
    check("t2_drop_pre", 32'(arb.Preempt_SO), 32'h0);
    tick();

    // Timeout preemption after exactly 16 cycles, then the other requester
    do_reset();
    arb.Req_DI = 4'b1001;
    tick();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t3_hold_%0d", i), 32'(arb.Gnt_DO), 32'h1);
      tick();
    end
    check("t3_gap_gnt", 32'(arb.Gnt_DO), 32'h0);
    check("t3_gap_pre", 32'(arb.Preempt_SO), 32'h1);
    check("t3_gap_busy", 32'(arb.Busy_SO), 32'h0);
    tick();
    check("t3_next_gnt", 32'(arb.Gnt_DO), 32'h8);
    check("t3_next_idx", 32'(arb.GntIdx_DO), 32'h3);
    check("t3_next_pre", 32'(arb.Preempt_SO), 32'h0);

    // Done coinciding with the last hold cycle is a voluntary release
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t4_hold_%0d", i), 32'(arb.Gnt_DO), 32'h8);
      if (i == 15) arb.Done_DI = 4'b1000;
      tick();
    end
    check("t4_done_gnt", 32'(arb.Gnt_DO), 32'h0);
    check("t4_done_pre", 32'(arb.Preempt_SO), 32'h0);
    arb.Done_DI = '0;
    tick();
    check("t4_wrap_gnt", 32'(arb.Gnt_DO), 32'h1);

    // Owner drops its request mid-grant
    tick();
    arb.Req_DI = 4'b1000;
    tick();
    check("t4_drop_gnt", 32'(arb.Gnt_DO), 32'h0);
    check("t4_drop_pre", 32'(arb.Preempt_SO), 32'h0);
    tick();
    check("t4_after_drop", 32'(arb.Gnt_DO), 32'h8);

    // Build Ptr=2 via owner 1, then reset during its grant
    arb.Req_DI = '0;
    tick();
    tick();
    arb.Req_DI = 4'b0010;
    tick();
    check("t5_gnt1", 32'(arb.Gnt_DO), 32'h2);
    arb.Done_DI = 4'b0010;
    tick();
    check("t5_gap", 32'(arb.Gnt_DO), 32'h0);
    arb.Done_DI = '0;
    tick();
    check("t5_lone_regrant", 32'(arb.Gnt_DO), 32'h2);
    rst = 1'b1;
    arb.Req_DI = 4'b1001;
    tick();
    check("t5_rst_gnt", 32'(arb.Gnt_DO), 32'h0);
    check("t5_rst_idx", 32'(arb.GntIdx_DO), 32'h0);
    check("t5_rst_pre", 32'(arb.Preempt_SO), 32'h0);
    rst = 1'b0;
    tick();
    check("t5_ptr0_gnt", 32'(arb.Gnt_DO), 32'h1);

    // Non-owner done pulses must not disturb grant, counter or pointer
    for (int i = 0; i < 16; i++) begin
      arb.Done_DI = (i % 2 == 1) ? 4'b1110 : 4'b0000;
      check($sformatf("t6_hold_%0d", i), 32'(arb.Gnt_DO), 32'h1);
      tick();
    end
    arb.Done_DI = '0;
    check("t6_to_gnt", 32'(arb.Gnt_DO), 32'h0);
    check("t6_to_pre", 32'(arb.Preempt_SO), 32'h1);
    tick();
    check("t6_next_gnt", 32'(arb.Gnt_DO), 32'h8);
    check("t6_next_pre", 32'(arb.Preempt_SO), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
